ifetch_unit: RTL and testbench

Instruction fetch unit sitting between the PC calculator and instruction memory. It consumes the current `pc`, issues one read per instruction over a valid/ready request channel, captures the response, and presents the instruction to decode. It drives `stay` back to the PC calculator so the PC holds until the instruction is consumed. This makes it the consumer end of the PC-calculator interface.

---
 rtl/ifetch_pkg.sv | 20 ++
 rtl/ifetch_timeout.sv | 40 ++++
 rtl/ifetch_unit.sv | 151 +++++++++++++++
 tb/tb_ifetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_e;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_BUSERR   = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

    // addi x0, x0, 0 -- presented in place of any faulted fetch
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifetch_timeout.sv
// Response watchdog: counts enabled cycles and flags expiry on the TIMEOUT_CYCLES-th one.
// Latency: expired is combinational from the count register, valid in the same cycle.
// Backpressure: none; clear has priority over enable, counter saturates at the last value.
module ifetch_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: restart on clear, otherwise advance while enabled until the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 16'd0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one imem read per pc, result presented to decode; IFETCH_TIMEOUT_EN adds a response watchdog.
// Latency: 3 cycles best case (request accepted, response, instruction presented).
// Backpressure: request held stable until imem_req_ready; ex_stall holds the presented instruction and stay.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        ex_stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        instr_fault,
    output logic [1:0]  fault_cause,
    output logic        stay
);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic        req_vld;

    // Watchdog hooks; tied off when the timeout feature is not built
    logic discard_q, discard_d;
    logic tmo_clear, tmo_enable, tmo_expired;

`ifdef IFETCH_TIMEOUT_EN
    ifetch_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Discard flag: set on timeout, cleared by the stale response it is waiting to swallow
    always_ff @(posedge clk) begin
        if (rst) begin
            discard_q <= 1'b0;
        end else begin
            discard_q <= discard_d;
        end
    end
`else
    assign discard_q   = 1'b0;
    assign tmo_expired = 1'b0;

    logic unused_tmo;
    assign unused_tmo = ^{discard_d, tmo_clear, tmo_enable, 32'(TIMEOUT_CYCLES)};
`endif

    // Next-state and capture logic for the fetch FSM
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
        req_vld    = 1'b0;
        tmo_clear  = 1'b0;
        tmo_enable = 1'b0;
        discard_d  = discard_q;

        // The first response seen while discarding belongs to a timed-out request
        if (discard_q && imem_rsp_valid) begin
            discard_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (pc[1:0] != 2'b00) begin
                    instr_d = NOP_INSTR;
                    fault_d = 1'b1;
                    cause_d = FC_MISALIGN;
                    state_d = S_VALID;
                end else if (!discard_q) begin
                    // No new request while a stale response may still be in flight
                    req_vld = 1'b1;
                    if (imem_req_ready) begin
                        tmo_clear = 1'b1;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                tmo_enable = 1'b1;
                if (imem_rsp_valid && !discard_q) begin
                    if (imem_rsp_err) begin
                        instr_d = NOP_INSTR;
                        fault_d = 1'b1;
                        cause_d = FC_BUSERR;
                    end else begin
                        instr_d = imem_rsp_data;
                        fault_d = 1'b0;
                        cause_d = FC_NONE;
                    end
                    state_d = S_VALID;
                end else if (tmo_expired) begin
                    instr_d   = NOP_INSTR;
                    fault_d   = 1'b1;
                    cause_d   = FC_TIMEOUT;
                    discard_d = 1'b1;
                    state_d   = S_VALID;
                end
            end
            S_VALID: begin
                if (!ex_stall) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // FSM and presentation registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            instr_q <= NOP_INSTR;
            fault_q <= 1'b0;
            cause_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    // Outputs are forced quiet during the reset cycle itself
    assign imem_req_valid = req_vld && !rst;
    assign imem_req_addr  = pc;
    assign instr          = instr_q;
    assign instr_fault    = fault_q;
    assign fault_cause    = cause_q;
    assign instr_valid    = (state_q == S_VALID) && !rst;
    assign stay           = rst || !((state_q == S_VALID) && !ex_stall);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an expected-instruction queue; IFETCH_TIMEOUT_EN enables the watchdog steps.
// Latency: checks the 3-cycle best case and stretched request/response/stall phases.
// Backpressure: exercises imem_req_ready low and ex_stall high.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ex_stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_fault;
    logic [1:0]  fault_cause;
    logic        stay;

    typedef struct packed {
        logic [31:0] ins;
        logic        flt;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    ifetch_unit #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .ex_stall       (ex_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_fault    (instr_fault),
        .fault_cause    (fault_cause),
        .stay           (stay)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // S_VALID phase: stall cycles of ex_stall=1 followed by one release cycle
    task automatic present(input string tag, input int stall);
        exp_t e;
        e = '0;
        for (int c = 0; c <= stall; c++) begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            imem_req_ready = 1'b0;
            ex_stall       = (c < stall);
            #1;
            if (c == 0) begin
                chk({tag, ".sb_pending"}, 32'(sb.size()), 32'd1);
                if (sb.size() > 0) e = sb.pop_front();
            end
            chk({tag, ".instr_valid"}, 32'(instr_valid), 32'd1);
            chk({tag, ".instr"}, instr, e.ins);
            chk({tag, ".fault"}, 32'(instr_fault), 32'(e.flt));
            chk({tag, ".cause"}, 32'(fault_cause), 32'(e.cause));
            chk({tag, ".stay"}, 32'(stay), 32'(c < stall));
            chk({tag, ".no_req"}, 32'(imem_req_valid), 32'd0);
        end
        ex_stall = 1'b0;
    endtask

    // One complete fetch: request phase (rdy_wait cycles of ready low), response phase, presentation
    task automatic fetch(input string tag, input logic [31:0] pc_v, input int rdy_wait,
                         input int rsp_wait, input logic [31:0] data, input logic err, input int stall);
        exp_t e;
        if (pc_v[1:0] != 2'b00) begin
            e = '{ins: NOP_INSTR, flt: 1'b1, cause: FC_MISALIGN};
            sb.push_back(e);
            @(negedge clk);
            pc             = pc_v;
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b0;
            #1;
            chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'd0);
            chk({tag, ".stay_req"}, 32'(stay), 32'd1);
        end else begin
            if (err) e = '{ins: NOP_INSTR, flt: 1'b1, cause: FC_BUSERR};
            else     e = '{ins: data, flt: 1'b0, cause: FC_NONE};
            sb.push_back(e);
            for (int c = 0; c <= rdy_wait; c++) begin
                @(negedge clk);
                pc             = pc_v;
                imem_rsp_valid = 1'b0;
                imem_req_ready = (c == rdy_wait);
                #1;
                chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'd1);
                chk({tag, ".req_addr"}, imem_req_addr, pc_v);
                chk({tag, ".stay_req"}, 32'(stay), 32'd1);
            end
            for (int c = 0; c <= rsp_wait; c++) begin
                @(negedge clk);
                imem_req_ready = 1'b0;
                imem_rsp_valid = (c == rsp_wait);
                imem_rsp_data  = (c == rsp_wait) ? data : 32'hDEAD_BEEF;
                imem_rsp_err   = (c == rsp_wait) ? err : 1'b0;
                #1;
                chk({tag, ".wait_no_req"}, 32'(imem_req_valid), 32'd0);
                chk({tag, ".wait_no_vld"}, 32'(instr_valid), 32'd0);
                chk({tag, ".stay_wait"}, 32'(stay), 32'd1);
            end
        end
        present(tag, stall);
    endtask

    initial begin
        rst            = 1'b1;
        pc             = 32'd0;
        ex_stall       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst.stay", 32'(stay), 32'd1);
        chk("rst.instr_valid", 32'(instr_valid), 32'd0);
        chk("rst.instr", instr, NOP_INSTR);
        chk("rst.fault", 32'(instr_fault), 32'd0);
        chk("rst.cause", 32'(fault_cause), 32'd0);

        // First S_REQ cycle after reset asserts the request
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_req.valid", 32'(imem_req_valid), 32'd1);
        chk("first_req.addr", imem_req_addr, 32'd0);

        fetch("basic",     32'h0000_0000, 0, 0, 32'h0050_0093, 1'b0, 0);
        fetch("rdy_hold",  32'h0000_0004, 3, 0, 32'h00A0_0113, 1'b0, 0);
        fetch("stall",     32'h0000_0008, 0, 2, 32'h0020_81B3, 1'b0, 5);
        fetch("misalign",  32'h0000_0102, 0, 0, 32'h0,         1'b0, 0);
        fetch("buserr",    32'h0000_000C, 1, 1, 32'hFFFF_FFFF, 1'b1, 0);
        fetch("after_err", 32'h0000_0010, 0, 0, 32'h1234_5678, 1'b0, 1);

        // Reset while waiting for a response returns to S_REQ
        @(negedge clk);
        pc             = 32'h0000_0014;
        imem_req_ready = 1'b1;
        #1;
        chk("midrst.req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst            = 1'b1;
        #1;
        chk("midrst.gated_req", 32'(imem_req_valid), 32'd0);
        chk("midrst.stay", 32'(stay), 32'd1);
        @(negedge clk);
        #1;
        chk("midrst.instr_valid", 32'(instr_valid), 32'd0);
        chk("midrst.instr", instr, NOP_INSTR);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst.back_in_req", 32'(imem_req_valid), 32'd1);
        fetch("post_rst",  32'h0000_0014, 0, 0, 32'h0000_0513, 1'b0, 0);

`ifdef IFETCH_TIMEOUT_EN
        begin
            exp_t e;
            e = '{ins: NOP_INSTR, flt: 1'b1, cause: FC_TIMEOUT};
            sb.push_back(e);
            @(negedge clk);
            pc             = 32'h0000_0018;
            imem_req_ready = 1'b1;
            #1;
            chk("tmo.req_valid", 32'(imem_req_valid), 32'd1);
            // Four S_WAIT cycles with no response, then the timeout is presented
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                imem_req_ready = 1'b0;
                imem_rsp_valid = 1'b0;
                #1;
                chk("tmo.wait_no_vld", 32'(instr_valid), 32'd0);
            end
            present("tmo", 0);
            // Discard flag blocks new requests until the late response appears
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                pc             = 32'h0000_001C;
                imem_req_ready = 1'b1;
                #1;
                chk("tmo.blocked_req", 32'(imem_req_valid), 32'd0);
                chk("tmo.blocked_stay", 32'(stay), 32'd1);
            end
            @(negedge clk);
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hBAD0_BAD0;
            imem_rsp_err   = 1'b0;
            #1;
            chk("tmo.late_rsp_no_req", 32'(imem_req_valid), 32'd0);
            fetch("after_tmo", 32'h0000_001C, 0, 0, 32'h0010_8093, 1'b0, 0);
        end
`endif

        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
